// File: rtl/cmdq_pkg.sv
// Shared types and helpers for the command-queue issue controller.
package cmdq_pkg;

  localparam int NQ_MAX = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cmdq_credit_ctr.sv
// Per-queue credit counter: starts full at DEPTH, decrements on enqueue,
// increments on dequeue, and flags a dequeue that would exceed DEPTH.
module cmdq_credit_ctr
  import cmdq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = cw(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_i,
  input  logic          deq_i,
  output logic [CW-1:0] credits_o,
  output logic          ready_o,
  output logic          full_o,
  output logic          overflow_o
);

  logic [CW-1:0] credits_q, credits_d;

  assign full_o     = (credits_q == CW'(DEPTH));
  assign ready_o    = (credits_q != '0);
  assign overflow_o = deq_i & ~enq_i & full_o;
  assign credits_o  = credits_q;

  // A returned credit beyond DEPTH is dropped; the top records the error.
  always_comb begin
    credits_d = credits_q;
    if (enq_i && !deq_i)
      credits_d = credits_q - CW'(1);
    else if (deq_i && !enq_i && !full_o)
      credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) credits_q <= CW'(DEPTH);
    else       credits_q <= credits_d;
  end

endmodule

// File: rtl/cmdq_issue_ctrl.sv
// Issue/replay control for NQ credit-tracked command queues with flush/drain FSM.
// Optional replay statistics counter enabled by defining CMDQ_STATS_EN.
module cmdq_issue_ctrl
  import cmdq_pkg::*;
#(
  parameter int NQ      = 2,
  parameter int DEPTH   = 4,
  parameter int STATS_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_valid,
  input  logic [NQ-1:0]      io_sigs_enq,
  input  logic [NQ-1:0]      io_deq,
  input  logic               io_flush,
  output logic               io_replay,
  output logic               io_fire,
  output logic [NQ-1:0]      io_enq_valid,
  output logic               io_drained,
  output logic               io_err,
  output logic [STATS_W-1:0] io_replay_cnt
);

  localparam int CW = cw(DEPTH);

  logic [NQ-1:0][CW-1:0] credits;
  logic [NQ-1:0]         ready, full, overflow, home;
  logic                  blocked;
  state_e                state_q;
  logic                  err_q;

  for (genvar g = 0; g < NQ; g++) begin : g_q
    cmdq_credit_ctr #(.DEPTH(DEPTH), .CW(CW)) u_ctr (
      .clk        (clk),
      .reset      (reset),
      .enq_i      (io_enq_valid[g]),
      .deq_i      (io_deq[g]),
      .credits_o  (credits[g]),
      .ready_o    (ready[g]),
      .full_o     (full[g]),
      .overflow_o (overflow[g])
    );
    assign home[g] = (credits[g] == CW'(DEPTH));
  end

  // Credits returned this cycle only become usable next cycle (no bypass).
  assign blocked      = (|(io_sigs_enq & ~ready)) | (state_q != RUN);
  assign io_replay    = io_valid & blocked;
  assign io_fire      = io_valid & ~blocked;
  assign io_enq_valid = io_sigs_enq & {NQ{io_fire}};
  assign io_drained   = (state_q == HOLD) & (&home);
  assign io_err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (io_flush) state_q <= DRAIN;
        DRAIN:   if (&full)    state_q <= HOLD;
        HOLD:    if (!io_flush) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          err_q <= 1'b0;
    else if (|overflow) err_q <= 1'b1;
  end

`ifdef CMDQ_STATS_EN
  logic [STATS_W-1:0] replay_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      replay_cnt_q <= '0;
    else if (io_replay && (replay_cnt_q != '1))
      replay_cnt_q <= replay_cnt_q + STATS_W'(1);
  end

  assign io_replay_cnt = replay_cnt_q;
`else
  assign io_replay_cnt = '0;
`endif

endmodule

// File: tb/tb_cmdq_issue_ctrl.sv
// Self-checking bench for cmdq_issue_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-level model.
module tb_cmdq_issue_ctrl;

  localparam int NQ      = 2;
  localparam int DEPTH   = 4;
  localparam int STATS_W = 2;
  localparam int SMAX    = (1 << STATS_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               io_valid, io_flush;
  logic [NQ-1:0]      io_sigs_enq, io_deq;
  logic               io_replay, io_fire, io_drained, io_err;
  logic [NQ-1:0]      io_enq_valid;
  logic [STATS_W-1:0] io_replay_cnt;

  always #5 clk = ~clk;

  cmdq_issue_ctrl #(.NQ(NQ), .DEPTH(DEPTH), .STATS_W(STATS_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_valid      (io_valid),
    .io_sigs_enq   (io_sigs_enq),
    .io_deq        (io_deq),
    .io_flush      (io_flush),
    .io_replay     (io_replay),
    .io_fire       (io_fire),
    .io_enq_valid  (io_enq_valid),
    .io_drained    (io_drained),
    .io_err        (io_err),
    .io_replay_cnt (io_replay_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: outstanding-free credit counts and a mode (0 run, 1 drain, 2 hold).
  int m_cred[NQ];
  int m_mode;
  bit m_err;
  int m_cnt;

  logic          a_rep, a_fire, a_drn;
  logic [NQ-1:0] a_enq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) m_cred[i] = DEPTH;
    m_mode = 0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic step(input logic v, input logic [NQ-1:0] s, input logic [NQ-1:0] d,
                      input logic f, input logic r);
    bit            blk, all_home, e_rep, e_fire, e_drn;
    logic [NQ-1:0] e_enq;
    int            c;
    io_valid = v; io_sigs_enq = s; io_deq = d; io_flush = f; reset = r;
    #2;
    blk = (m_mode != 0);
    all_home = 1'b1;
    for (int i = 0; i < NQ; i++) begin
      if (s[i] && m_cred[i] == 0) blk = 1'b1;
      if (m_cred[i] != DEPTH) all_home = 1'b0;
    end
    e_rep  = v && blk;
    e_fire = v && !blk;
    e_enq  = e_fire ? s : '0;
    e_drn  = (m_mode == 2) && all_home;
    chk("replay", io_replay, e_rep);
    chk("fire", io_fire, e_fire);
    chk("enq_valid", io_enq_valid, e_enq);
    chk("drained", io_drained, e_drn);
    chk("err", io_err, m_err);
    chk("replay_cnt", io_replay_cnt, m_cnt);
    a_rep = io_replay; a_fire = io_fire; a_enq = io_enq_valid; a_drn = io_drained;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < NQ; i++) begin
        c = m_cred[i] + int'(d[i]) - int'(e_enq[i]);
        if (c > DEPTH) begin m_err = 1'b1; c = DEPTH; end
        m_cred[i] = c;
      end
      if (m_mode == 0 && f)             m_mode = 1;
      else if (m_mode == 1 && all_home) m_mode = 2;
      else if (m_mode == 2 && !f)       m_mode = 0;
`ifdef CMDQ_STATS_EN
      if (e_rep && m_cnt < SMAX) m_cnt++;
`endif
    end
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [NQ-1:0] s;
    logic [NQ-1:0] d;
    logic          f;
    logic          rep;
    logic          fire;
    logic          drn;
  } vec_t;

  vec_t tv[$];
  int   fires;
  bit   fl;

  initial begin
    // Directed vectors from a fresh reset (credits 4/4, RUN).
    for (int i = 0; i < 4; i++) tv.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}); // q0 empty -> replay
    tv.push_back('{1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0}); // return not bypassed
    tv.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}); // usable next cycle
    tv.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0}); // q0 at 2
    tv.push_back('{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0}); // enq+deq: stays 2
    tv.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) tv.push_back('{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}); // q1 at 3
    tv.push_back('{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0}); // flush cycle still RUN
    tv.push_back('{1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0}); // DRAIN, q1 home
    tv.push_back('{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0}); // DRAIN, all home
    tv.push_back('{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1}); // HOLD, sigs ignored
    tv.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1}); // HOLD, flush released
    tv.push_back('{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}); // back in RUN

    model_reset();
    io_valid = 1'b0; io_sigs_enq = '0; io_deq = '0; io_flush = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    // Reset state: nothing replays, issue to full queues fires.
    step(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    chk("rst_fire", a_fire, 1'b1);
    chk("rst_enq", a_enq, 2'b11);
    chk("rst_replay", a_rep, 1'b0);
    step(1'b0, 2'b00, 2'b11, 1'b0, 1'b0);

    foreach (tv[i]) begin
      step(tv[i].v, tv[i].s, tv[i].d, tv[i].f, 1'b0);
      chk($sformatf("tv%0d_replay", i), a_rep, tv[i].rep);
      chk($sformatf("tv%0d_fire", i), a_fire, tv[i].fire);
      chk($sformatf("tv%0d_enq", i), a_enq, tv[i].fire ? tv[i].s : 2'b00);
      chk($sformatf("tv%0d_drained", i), a_drn, tv[i].drn);
    end

    // Overflowing credit return: sticky error, counter stays at DEPTH.
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("err_after_reset", io_err, 1'b0);
    step(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    chk("err_set", io_err, 1'b1);
    fires = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
      fires += int'(a_fire);
    end
    chk("ovf_credits_fires", fires, 4);
    chk("ovf_last_replay", a_rep, 1'b1);
    chk("err_sticky", io_err, 1'b1);

    // Replay statistics: five replay cycles.
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("err_cleared", io_err, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
`ifdef CMDQ_STATS_EN
    chk("stats_saturate", io_replay_cnt, 3);
`else
    chk("stats_absent", io_replay_cnt, 0);
`endif

    // Reset in the middle of a drain: RUN again with every credit restored.
    step(1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("drain_replay", a_rep, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    fires = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
      fires += int'(a_fire);
    end
    chk("middrain_rst_fires", fires, 4);
    chk("middrain_rst_replay", a_rep, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

    // Random traffic against the model.
    fl = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [NQ-1:0] d;
      for (int i = 0; i < NQ; i++)
        d[i] = (m_cred[i] < DEPTH) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) fl = ~fl;
      step($urandom_range(0, 3) != 0, NQ'($urandom), d, fl, $urandom_range(0, 149) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
